// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants shared by the instruction-fetch stage.
//   WORD_ZERO          all-zero machine word
//   NOP_INSTR_VAL      instruction injected into IF/ID on reset/flush/redirect
//   PC_STEP_VAL        sequential PC increment
//   S_FETCH/S_HOLD/S_DROP  fetch FSM state encodings
package fetch_stage_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam logic [31:0] WORD_ZERO     = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_VAL = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_VAL   = 32'd4;

  // Fetch FSM encodings
  localparam logic [1:0] S_FETCH = 2'd0;  // request outstanding at pc_in
  localparam logic [1:0] S_HOLD  = 2'd1;  // word captured while IF/ID stalled
  localparam logic [1:0] S_DROP  = 2'd2;  // wrong-path request still in flight

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg: IF/ID pipeline register.
//   clk, rst       clock, asynchronous active-low reset
//   load           capture {instr_in, pc4_in} and mark valid
//   clear          invalidate (valid=0, instr=NOP); wins over load
//   instr_in/pc4_in  values to capture
//   instr/pc4/valid  registered contents
// With neither load nor clear the register holds.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_VAL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Next-state selection: clear > load > hold. The pc4 field is left alone on clear.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (clear) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register update with asynchronous reset to an empty NOP slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= XLEN'(WORD_ZERO);
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting after the PC register.
//   clk, rst                 clock, asynchronous active-low reset
//   pc_in / next_pc          current PC in, value the PC register latches next (comb)
//   imem_req/addr/ready/rdata  variable-latency instruction memory handshake
//   branch_taken/target      redirect from EX
//   stall, flush             IF/ID hazard controls
//   if_id_instr/pc4/valid    IF/ID pipeline register outputs
// Optional (macro FETCH_PERF_CNT_EN): perf_fetched, perf_stall 32-bit wrapping counters.
// The PC is held by returning pc_in on next_pc. A redirect or flush invalidates IF/ID;
// flush never changes the PC. A redirect that arrives while a request is still
// outstanding parks the target and drains that request in S_DROP.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP   = XLEN'(PC_STEP_VAL),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_VAL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic [XLEN-1:0] hold_buf_q, hold_buf_d;
  logic [XLEN-1:0] pc4_s;
  logic [XLEN-1:0] ifid_instr_s;
  logic            ifid_load_s;
  logic            ifid_clear_s;

  // Wraps modulo 2^XLEN by construction
  assign pc4_s     = pc_in + PC_STEP;
  assign imem_addr = pc_in;

  // FSM, next-PC mux, memory request and IF/ID control
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    hold_buf_d   = hold_buf_q;
    next_pc      = pc_in;
    imem_req     = 1'b0;
    ifid_load_s  = 1'b0;
    ifid_clear_s = 1'b0;
    ifid_instr_s = imem_rdata;
    if (!rst) begin
      // Request is dropped while reset is low; flops are held by the async reset
      imem_req = 1'b0;
    end else begin
      ifid_clear_s = flush | branch_taken;
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            if (imem_ready) begin
              next_pc = branch_target;
            end else begin
              // Keep the request up at the same address until it completes
              pending_d = branch_target;
              state_d   = S_DROP;
            end
          end else if (imem_ready) begin
            if (stall) begin
              hold_buf_d = imem_rdata;
              state_d    = S_HOLD;
            end else begin
              next_pc     = pc4_s;
              ifid_load_s = 1'b1;
            end
          end else begin
            next_pc = pc_in;
          end
        end
        S_HOLD: begin
          ifid_instr_s = hold_buf_q;
          if (branch_taken) begin
            next_pc = branch_target;
            state_d = S_FETCH;
          end else if (!stall) begin
            // pc_in has been held, so pc4_s still belongs to the buffered word
            next_pc     = pc4_s;
            ifid_load_s = 1'b1;
            state_d     = S_FETCH;
          end else begin
            next_pc = pc_in;
          end
        end
        S_DROP: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            // A newer redirect supersedes the parked one
            if (imem_ready) begin
              next_pc   = branch_target;
              pending_d = XLEN'(WORD_ZERO);
              state_d   = S_FETCH;
            end else begin
              pending_d = branch_target;
            end
          end else if (imem_ready) begin
            next_pc   = pending_q;
            pending_d = XLEN'(WORD_ZERO);
            state_d   = S_FETCH;
          end else begin
            next_pc = pc_in;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // FSM state, parked redirect target and stall hold buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pending_q  <= XLEN'(WORD_ZERO);
      hold_buf_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      hold_buf_q <= hold_buf_d;
    end
  end

  fetch_stage_if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load_s),
    .clear    (ifid_clear_s),
    .instr_in (ifid_instr_s),
    .pc4_in   (pc4_s),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count real IF/ID loads and cycles spent waiting on memory or the hazard unit
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (ifid_load_s && !ifid_clear_s) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end else begin
      perf_fetched_d = perf_fetched_q;
    end
    if (rst && ((state_q == S_HOLD) || !imem_ready)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        flush;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .next_pc       (next_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .flush         (flush),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rdy;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] tgt;
    logic        st;
    logic        fl;
    logic [31:0] e_npc;
    logic        e_req;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    string       tag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [31:0] pc, input logic rdy, input logic [31:0] rdata,
                              input logic br, input logic [31:0] tgt, input logic st, input logic fl,
                              input logic [31:0] e_npc, input logic e_req,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
    vec_t v;
    v.pc = pc; v.rdy = rdy; v.rdata = rdata; v.br = br; v.tgt = tgt; v.st = st; v.fl = fl;
    v.e_npc = e_npc; v.e_req = e_req; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pc_in         = v.pc;
    imem_ready    = v.rdy;
    imem_rdata    = v.rdata;
    branch_taken  = v.br;
    branch_target = v.tgt;
    stall         = v.st;
    flush         = v.fl;
  endtask

  // One cycle: drive at negedge, check comb outputs, check IF/ID after the edge
  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    sb_t got;
    @(negedge clk);
    drive(v);
    e.instr = v.e_instr; e.pc4 = v.e_pc4; e.valid = v.e_valid; e.tag = tag;
    sb_q.push_back(e);
    #1;
    chk({tag, "/next_pc"}, next_pc, v.e_npc);
    chk({tag, "/imem_req"}, {31'd0, imem_req}, {31'd0, v.e_req});
    chk({tag, "/imem_addr"}, imem_addr, v.pc);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk({got.tag, "/if_id_instr"}, if_id_instr, got.instr);
      chk({got.tag, "/if_id_pc4"}, if_id_pc4, got.pc4);
      chk({got.tag, "/if_id_valid"}, {31'd0, if_id_valid}, {31'd0, got.valid});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(mk(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0));
    #12;
    chk("reset/if_id_valid", {31'd0, if_id_valid}, 32'd0);
    chk("reset/if_id_instr", if_id_instr, 32'h0000_0000);
    chk("reset/if_id_pc4", if_id_pc4, 32'd0);
    chk("reset/imem_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    //                pc            rdy   rdata          br    tgt          st    fl    e_npc         req   e_instr        e_pc4       e_valid
    vecs.push_back(mk(32'd0,        1'b1, 32'h2002_0005, 1'b0, 32'd0,       1'b0, 1'b0, 32'd4,        1'b1, 32'h2002_0005, 32'd4,      1'b1));
    vecs.push_back(mk(32'd4,        1'b1, 32'h0000_0011, 1'b0, 32'd0,       1'b0, 1'b0, 32'd8,        1'b1, 32'h0000_0011, 32'd8,      1'b1));
    vecs.push_back(mk(32'd8,        1'b0, 32'hDEAD_0001, 1'b0, 32'd0,       1'b0, 1'b0, 32'd8,        1'b1, 32'h0000_0011, 32'd8,      1'b1));
    vecs.push_back(mk(32'd8,        1'b0, 32'hDEAD_0002, 1'b0, 32'd0,       1'b0, 1'b0, 32'd8,        1'b1, 32'h0000_0011, 32'd8,      1'b1));
    vecs.push_back(mk(32'd8,        1'b0, 32'hDEAD_0003, 1'b0, 32'd0,       1'b0, 1'b0, 32'd8,        1'b1, 32'h0000_0011, 32'd8,      1'b1));
    vecs.push_back(mk(32'd8,        1'b1, 32'h0000_0033, 1'b0, 32'd0,       1'b0, 1'b0, 32'd12,       1'b1, 32'h0000_0033, 32'd12,     1'b1));
    vecs.push_back(mk(32'd12,       1'b1, 32'h0000_0044, 1'b0, 32'd0,       1'b0, 1'b0, 32'd16,       1'b1, 32'h0000_0044, 32'd16,     1'b1));
    vecs.push_back(mk(32'd16,       1'b1, 32'h0000_0055, 1'b0, 32'd0,       1'b1, 1'b0, 32'd16,       1'b1, 32'h0000_0044, 32'd16,     1'b1));
    vecs.push_back(mk(32'd16,       1'b0, 32'hDEAD_0004, 1'b0, 32'd0,       1'b1, 1'b0, 32'd16,       1'b0, 32'h0000_0044, 32'd16,     1'b1));
    vecs.push_back(mk(32'd16,       1'b0, 32'hDEAD_0005, 1'b0, 32'd0,       1'b0, 1'b0, 32'd20,       1'b0, 32'h0000_0055, 32'd20,     1'b1));
    vecs.push_back(mk(32'd20,       1'b1, 32'h0000_0066, 1'b0, 32'd0,       1'b0, 1'b0, 32'd24,       1'b1, 32'h0000_0066, 32'd24,     1'b1));
    vecs.push_back(mk(32'd24,       1'b0, 32'hDEAD_0006, 1'b1, 32'h40,      1'b0, 1'b0, 32'd24,       1'b1, 32'h0000_0000, 32'd24,     1'b0));
    vecs.push_back(mk(32'd24,       1'b0, 32'hDEAD_0007, 1'b0, 32'd0,       1'b0, 1'b0, 32'd24,       1'b1, 32'h0000_0000, 32'd24,     1'b0));
    vecs.push_back(mk(32'd24,       1'b1, 32'h0000_0077, 1'b0, 32'd0,       1'b0, 1'b0, 32'h40,       1'b1, 32'h0000_0000, 32'd24,     1'b0));
    vecs.push_back(mk(32'h40,       1'b1, 32'h0000_0088, 1'b0, 32'd0,       1'b0, 1'b0, 32'h44,       1'b1, 32'h0000_0088, 32'h44,     1'b1));
    vecs.push_back(mk(32'h44,       1'b0, 32'hDEAD_0008, 1'b0, 32'd0,       1'b1, 1'b1, 32'h44,       1'b1, 32'h0000_0000, 32'h44,     1'b0));
    vecs.push_back(mk(32'h44,       1'b1, 32'h0000_0099, 1'b1, 32'h100,     1'b0, 1'b0, 32'h100,      1'b1, 32'h0000_0000, 32'h44,     1'b0));
    vecs.push_back(mk(32'h100,      1'b1, 32'h0000_00AA, 1'b0, 32'd0,       1'b1, 1'b0, 32'h100,      1'b1, 32'h0000_0000, 32'h44,     1'b0));
    vecs.push_back(mk(32'h100,      1'b0, 32'hDEAD_0009, 1'b1, 32'h200,     1'b1, 1'b0, 32'h200,      1'b0, 32'h0000_0000, 32'h44,     1'b0));
    vecs.push_back(mk(32'h200,      1'b0, 32'hDEAD_000A, 1'b1, 32'h300,     1'b0, 1'b0, 32'h200,      1'b1, 32'h0000_0000, 32'h44,     1'b0));
    vecs.push_back(mk(32'h200,      1'b0, 32'hDEAD_000B, 1'b1, 32'h400,     1'b0, 1'b0, 32'h200,      1'b1, 32'h0000_0000, 32'h44,     1'b0));
    vecs.push_back(mk(32'h200,      1'b1, 32'h0000_00BB, 1'b0, 32'd0,       1'b0, 1'b0, 32'h400,      1'b1, 32'h0000_0000, 32'h44,     1'b0));
    vecs.push_back(mk(32'hFFFF_FFFC,1'b1, 32'h0000_00CC, 1'b0, 32'd0,       1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_00CC, 32'd0,      1'b1));
    vecs.push_back(mk(32'd0,        1'b1, 32'h0000_00DD, 1'b0, 32'd0,       1'b0, 1'b1, 32'd4,        1'b1, 32'h0000_0000, 32'd0,      1'b0));
    vecs.push_back(mk(32'd4,        1'b1, 32'h0000_00EE, 1'b0, 32'd0,       1'b0, 1'b0, 32'd8,        1'b1, 32'h0000_00EE, 32'd8,      1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset pulsed low in the middle of an outstanding request
    @(negedge clk);
    drive(mk(32'd8, 1'b0, 32'hDEAD_00FF, 1'b0, 32'd0, 1'b0, 1'b0, 32'd8, 1'b1, 32'd0, 32'd0, 1'b0));
    #1;
    chk("midrst_pre/imem_req", {31'd0, imem_req}, 32'd1);
    chk("midrst_pre/next_pc", next_pc, 32'd8);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst/imem_req", {31'd0, imem_req}, 32'd0);
    chk("midrst/if_id_valid", {31'd0, if_id_valid}, 32'd0);
    chk("midrst/if_id_instr", if_id_instr, 32'h0000_0000);
    chk("midrst/if_id_pc4", if_id_pc4, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply(mk(32'd8, 1'b1, 32'h0000_1234, 1'b0, 32'd0, 1'b0, 1'b0, 32'd12, 1'b1, 32'h0000_1234, 32'd12, 1'b1), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
